pc_main: RTL and testbench
==========================

Name: pc_main

Overview:
- Program counter for the RAT CPU: a 10-bit registered instruction address with a 4-way next-address multiplexer.
- Sits between the control unit (PC_LD, PC_INC, PC_MUX_SEL) and the program ROM address input (PC_COUNT).
- Next-address sources are the instruction immediate, the stack return address, the interrupt vector and zero.

Parameters:
- WIDTH, 10, width of the address datapath and of every address port.
- INTR_VEC, 10'h3FF, constant address selected when PC_MUX_SEL = 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low; while low, PC_COUNT is held at 0.
- PC_LD  input  1  load enable; on a clock edge, PC_COUNT takes the mux output.
- PC_INC  input  1  increment enable; on a clock edge, PC_COUNT takes PC_COUNT + 1.
- PC_MUX_SEL  input  2  next-address select: 0 = FROM_IMMED, 1 = FROM_STACK, 2 = INTR_VEC, 3 = 0.
- FROM_IMMED  input  WIDTH  branch/call target taken from the instruction.
- FROM_STACK  input  WIDTH  return address popped from the stack.
- PC_COUNT  output  WIDTH  current program counter value, a register output.

Behaviour:
- Single register PC_COUNT drives the output directly; there is no combinational path from inputs to PC_COUNT.
- Reset:
  - RST low asynchronously clears PC_COUNT to 0, independent of CLK.
  - PC_COUNT stays 0 while RST is low, regardless of PC_LD or PC_INC.
  - First update is on the first rising CLK edge after RST returns high.
- Mux: combinational, selected by PC_MUX_SEL.
  - 0 → FROM_IMMED
  - 1 → FROM_STACK
  - 2 → INTR_VEC (10'h3FF)
  - 3 → 0
- Update on rising CLK edge, with RST high, in priority order:
  - PC_LD = 1: PC_COUNT <= mux output. PC_LD wins when PC_LD and PC_INC are both 1.
  - else PC_INC = 1: PC_COUNT <= PC_COUNT + 1, modulo 2^WIDTH, so 10'h3FF wraps to 10'h000.
  - else: PC_COUNT holds.
- Latency: one cycle. A new value is visible after the capturing edge; inputs are sampled only at the edge.
- FROM_IMMED, FROM_STACK and PC_MUX_SEL are ignored unless PC_LD = 1.
- Reset asserted mid-load or mid-increment: reset wins immediately and the pending update is discarded.
- Unsigned arithmetic only; no overflow flag.

Test Plan:
- Reset: RST = 0 with PC_LD = 1, PC_INC = 1, FROM_IMMED = 3 → PC_COUNT = 0 immediately (before any edge) and held over 3 edges. Release RST → PC_COUNT follows the load on the next edge.
- Increment/hold: RST = 1, PC_COUNT = 0; PC_INC = 1 for one edge → 1; PC_INC = 0 for one edge → stays 1; PC_INC = 1 for 5 edges → 6.
- Load sources:
  - PC_LD = 1, FROM_IMMED = 3, FROM_STACK = 2.
  - SEL = 0 → 3; SEL = 1 → 2; SEL = 2 → 0x3FF; SEL = 3 → 0, each one edge after the change.
- Priority: PC_COUNT = 5, PC_LD = 1, PC_INC = 1, SEL = 1, FROM_STACK = 2 → 2 (not 6). Then PC_LD = 0, PC_INC = 1 → 3.
- Wrap: load INTR_VEC (0x3FF), then PC_INC = 1 for one edge → 0x000; one more edge → 0x001.
- Async reset mid-run: increment to 7, then pulse RST low between edges → PC_COUNT = 0 without a clock edge; next edge after release with PC_INC = 1 → 1.

Source files
------------

// File: rtl/pc_main_if.sv
// pc_main_if: control-unit to program-counter bundle.
// Carries load/increment controls, next-address sources and the PC value.
interface pc_main_if #(
    parameter int WIDTH = 10
);
    logic             PC_LD;
    logic             PC_INC;
    logic [1:0]       PC_MUX_SEL;
    logic [WIDTH-1:0] FROM_IMMED;
    logic [WIDTH-1:0] FROM_STACK;
    logic [WIDTH-1:0] PC_COUNT;

    modport master (
        output PC_LD,
        output PC_INC,
        output PC_MUX_SEL,
        output FROM_IMMED,
        output FROM_STACK,
        input  PC_COUNT
    );

    modport slave (
        input  PC_LD,
        input  PC_INC,
        input  PC_MUX_SEL,
        input  FROM_IMMED,
        input  FROM_STACK,
        output PC_COUNT
    );
endinterface

// File: rtl/pc_main.sv
// pc_main: RAT CPU program counter.
// Registered address with a 4-way next-address mux; load beats increment.
module pc_main #(
    parameter int               WIDTH    = 10,
    parameter logic [WIDTH-1:0] INTR_VEC = 10'h3FF
) (
    input logic     CLK,
    input logic     RST,
    pc_main_if.slave bus
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] mux_out;

    // next-address source select
    always_comb begin
        mux_out = '0;
        case (bus.PC_MUX_SEL)
            2'd0: mux_out = bus.FROM_IMMED;
            2'd1: mux_out = bus.FROM_STACK;
            2'd2: mux_out = INTR_VEC;
            2'd3: mux_out = '0;
            default: mux_out = '0;
        endcase
    end

    // PC register: async clear, then load > increment > hold
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q <= '0;
        end else if (bus.PC_LD) begin
            pc_q <= mux_out;
        end else if (bus.PC_INC) begin
            pc_q <= pc_q + WIDTH'(1);
        end
    end

    assign bus.PC_COUNT = pc_q;

endmodule

// File: tb/tb_pc_main.sv
// tb_pc_main: directed checks of pc_main.
// Expected values are queued as each step is driven, then popped at check.
module tb_pc_main;

    logic CLK;
    logic RST;

    int total;
    int bad;

    logic [9:0] exp_q[$];

    pc_main_if #(.WIDTH(10)) bus ();

    pc_main #(.WIDTH(10), .INTR_VEC(10'h3FF)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag);
        logic [9:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, bus.PC_COUNT);
        end else begin
            e = exp_q.pop_front();
            assert (bus.PC_COUNT === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, bus.PC_COUNT, e);
            end
        end
    endtask

    task automatic drive(input logic ld, input logic inc, input logic [1:0] sel,
                         input logic [9:0] imm, input logic [9:0] stk);
        bus.PC_LD      = ld;
        bus.PC_INC     = inc;
        bus.PC_MUX_SEL = sel;
        bus.FROM_IMMED = imm;
        bus.FROM_STACK = stk;
    endtask

    task automatic step(input string tag, input logic ld, input logic inc,
                        input logic [1:0] sel, input logic [9:0] imm,
                        input logic [9:0] stk, input logic [9:0] e);
        drive(ld, inc, sel, imm, stk);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        drive(1'b1, 1'b1, 2'd0, 10'd3, 10'd2);

        // async reset before any clock edge
        #2;
        RST = 1'b0;
        #1;
        exp_q.push_back(10'd0);
        check("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            exp_q.push_back(10'd0);
            check("rst_hold");
        end

        // release: load on first edge
        RST = 1'b1;
        step("rst_release_ld", 1'b1, 1'b1, 2'd0, 10'd3, 10'd2, 10'd3);

        // clear to zero, then increment / hold
        step("ld_zero", 1'b1, 1'b0, 2'd3, 10'd3, 10'd2, 10'd0);
        step("inc1", 1'b0, 1'b1, 2'd0, 10'd3, 10'd2, 10'd1);
        step("hold", 1'b0, 1'b0, 2'd1, 10'h155, 10'h2AA, 10'd1);
        for (int i = 0; i < 5; i++)
            step("inc5", 1'b0, 1'b1, 2'd2, 10'd3, 10'd2, 10'(i + 2));

        // every load source
        step("ld_immed", 1'b1, 1'b0, 2'd0, 10'd3, 10'd2, 10'd3);
        step("ld_stack", 1'b1, 1'b0, 2'd1, 10'd3, 10'd2, 10'd2);
        step("ld_intr", 1'b1, 1'b0, 2'd2, 10'd3, 10'd2, 10'h3FF);
        step("ld_zero_sel", 1'b1, 1'b0, 2'd3, 10'd3, 10'd2, 10'd0);
        step("ld_immed_wide", 1'b1, 1'b0, 2'd0, 10'h2A5, 10'h15A, 10'h2A5);
        step("ld_stack_wide", 1'b1, 1'b0, 2'd1, 10'h2A5, 10'h15A, 10'h15A);

        // load beats increment
        step("ld5", 1'b1, 1'b0, 2'd0, 10'd5, 10'd2, 10'd5);
        step("prio_ld", 1'b1, 1'b1, 2'd1, 10'd5, 10'd2, 10'd2);
        step("prio_inc", 1'b0, 1'b1, 2'd1, 10'd5, 10'd2, 10'd3);

        // wrap at the top of the address space
        step("wrap_ld", 1'b1, 1'b0, 2'd2, 10'd0, 10'd0, 10'h3FF);
        step("wrap_inc", 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'h000);
        step("wrap_inc2", 1'b0, 1'b1, 2'd2, 10'd0, 10'd0, 10'h001);

        // async reset mid-run
        step("mid_ld0", 1'b1, 1'b0, 2'd3, 10'd0, 10'd0, 10'd0);
        for (int i = 0; i < 7; i++)
            step("mid_inc", 1'b0, 1'b1, 2'd0, 10'd0, 10'd0, 10'(i + 1));
        #1;
        RST = 1'b0;
        #1;
        exp_q.push_back(10'd0);
        check("mid_rst_async");
        RST = 1'b1;
        #1;
        exp_q.push_back(10'd0);
        check("mid_rst_release");
        step("mid_after_inc", 1'b0, 1'b1, 2'd0, 10'd0, 10'd0, 10'd1);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
